// File: rtl/seg7_capture_if.sv
// Glyph bus and digit handshake between a 7-segment source/consumer and seg7_capture.
// The master drives glyphs and digit_ready; the slave (capture block) returns the decoded digit.
interface seg7_capture_if;
   logic [6:0] seg_in;
   logic       seg_strobe;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       digit_ready;

   modport master (
      output seg_in,
      output seg_strobe,
      output digit_ready,
      input  digit_out,
      input  digit_valid
   );

   modport slave (
      input  seg_in,
      input  seg_strobe,
      input  digit_ready,
      output digit_out,
      output digit_valid
   );
endinterface

// File: rtl/seg7_capture.sv
// Debounces an active-low 7-segment glyph bus, decodes it to BCD and accumulates digits.
// Optional macro SEG7_CAPTURE_ALT_GLYPH_EN: also accept the alternate 6, 7 and 9 glyphs.
module seg7_capture #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned DIGITS        = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_capture_if.slave         bus,
   input  logic                  clear,
   output logic                  invalid_err,
   output logic [4*DIGITS-1:0]   bcd_value,
   output logic [3:0]            value_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DECODE,
      EMIT
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] digit;
   } glyph_t;

   localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
   localparam logic [3:0] DIGITS_N = 4'(DIGITS);

   // Segment order {a,b,c,d,e,f,g}, 0 = lit.
   function automatic glyph_t decode_glyph(input logic [6:0] g);
      glyph_t r;
      r = '{legal: 1'b0, blank: 1'b0, digit: 4'd0};
      case (g)
         7'b0000001: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd0};
         7'b1001111: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd1};
         7'b0010010: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd2};
         7'b0000110: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd3};
         7'b1001100: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd4};
         7'b0100100: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd5};
         7'b0100000: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd6};
         7'b0001111: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd7};
         7'b0000000: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd8};
         7'b0000100: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd9};
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
         7'b1100000: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd6};
         7'b0001101: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd7};
         7'b0001100: r = '{legal: 1'b1, blank: 1'b0, digit: 4'd9};
`endif
         7'b1111111: r = '{legal: 1'b0, blank: 1'b1, digit: 4'd0};
         default:    r = '{legal: 1'b0, blank: 1'b0, digit: 4'd0};
      endcase
      return r;
   endfunction

   state_t     state;
   state_t     state_next;
   logic [6:0] shadow;
   logic [6:0] shadow_next;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       emit_load;
   logic       err_set;
   logic       xfer;
   glyph_t     glyph;

   logic [4*DIGITS-1:0] bcd_shifted;

   assign glyph = decode_glyph(shadow);

   // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next  = state;
      shadow_next = shadow;
      cnt_next    = cnt;
      emit_load   = 1'b0;
      err_set     = 1'b0;
      xfer        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.seg_strobe) begin
               shadow_next = bus.seg_in;
               cnt_next    = 4'd1;
               state_next  = (STABLE_N == 4'd1) ? DECODE : SETTLE;
            end
         end
         SETTLE: begin
            if (bus.seg_in == shadow) begin
               cnt_next = cnt + 4'd1;
               if (cnt + 4'd1 == STABLE_N) begin
                  state_next = DECODE;
               end
            end else begin
               // Any glyph change restarts the stability window.
               shadow_next = bus.seg_in;
               cnt_next    = 4'd1;
            end
         end
         DECODE: begin
            if (glyph.legal) begin
               emit_load  = 1'b1;
               state_next = EMIT;
            end else begin
               err_set    = !glyph.blank;
               state_next = IDLE;
            end
         end
         EMIT: begin
            if (bus.digit_ready) begin
               xfer       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow          <= 7'h7f;
         cnt             <= 4'd0;
         bus.digit_out   <= 4'd0;
         bus.digit_valid <= 1'b0;
         invalid_err     <= 1'b0;
      end else begin
         shadow      <= shadow_next;
         cnt         <= cnt_next;
         invalid_err <= err_set;
         if (emit_load) begin
            bus.digit_out   <= glyph.digit;
            bus.digit_valid <= 1'b1;
         end else if (xfer) begin
            bus.digit_valid <= 1'b0;
         end
      end
   end

   generate
      if (DIGITS == 1) begin : g_single
         assign bcd_shifted = bus.digit_out;
      end else begin : g_multi
         assign bcd_shifted = {bcd_value[4*DIGITS-5:0], bus.digit_out};
      end
   endgenerate

   // clear beats a transfer on the same edge; reset beats both.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bcd_value   <= '0;
         value_count <= 4'd0;
      end else if (xfer) begin
         bcd_value <= bcd_shifted;
         if (value_count < DIGITS_N) begin
            value_count <= value_count + 4'd1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg7_capture.sv
// Directed-vector bench for seg7_capture (STABLE_CYCLES=4, DIGITS=2).
// Honors SEG7_CAPTURE_ALT_GLYPH_EN for the alternate-glyph case.
module tb_seg7_capture;
   logic       clk;
   logic       reset;
   logic       clear;
   logic       invalid_err;
   logic [7:0] bcd_value;
   logic [3:0] value_count;
   logic       busy;

   int n_checks;
   int n_fail;
   int lat;

   logic [6:0] glyphs [10];

   seg7_capture_if bus ();

   seg7_capture #(
      .STABLE_CYCLES(4),
      .DIGITS       (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .clear      (clear),
      .invalid_err(invalid_err),
      .bcd_value  (bcd_value),
      .value_count(value_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [6:0] g);
      bus.seg_in     = g;
      bus.seg_strobe = 1'b1;
      tick();
      bus.seg_strobe = 1'b0;
   endtask

   // Bounded wait for digit_valid or invalid_err; returns cycles waited.
   task automatic wait_event(output int n);
      n = 0;
      while (!(bus.digit_valid || invalid_err) && n < 20) begin
         tick();
         n++;
      end
   endtask

   // Capture one glyph with digit_ready high and check the decoded digit.
   task automatic accept(input logic [6:0] g, input logic [3:0] d);
      int n;
      bus.digit_ready = 1'b1;
      strobe(g);
      wait_event(n);
      check("accept_latency", n, 4);
      check("accept_digit", bus.digit_out, d);
      tick();
      check("accept_done", bus.digit_valid, 0);
   endtask

   initial begin
      logic saw;
      n_checks = 0;
      n_fail   = 0;
      glyphs[0] = 7'b0000001; glyphs[1] = 7'b1001111; glyphs[2] = 7'b0010010;
      glyphs[3] = 7'b0000110; glyphs[4] = 7'b1001100; glyphs[5] = 7'b0100100;
      glyphs[6] = 7'b0100000; glyphs[7] = 7'b0001111; glyphs[8] = 7'b0000000;
      glyphs[9] = 7'b0000100;

      reset           = 1'b1;
      clear           = 1'b0;
      bus.seg_in      = 7'h7f;
      bus.seg_strobe  = 1'b0;
      bus.digit_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", bus.digit_valid, 0);
      check("rst_digit", bus.digit_out, 0);
      check("rst_err", invalid_err, 0);
      check("rst_bcd", bcd_value, 8'h00);
      check("rst_count", value_count, 0);
      check("rst_busy", busy, 0);

      // Basic capture of '2' with ready already high.
      bus.digit_ready = 1'b1;
      strobe(7'b0010010);
      check("t1_busy", busy, 1);
      tick(); tick(); tick();
      check("t1_not_yet", bus.digit_valid, 0);
      tick();
      check("t1_valid", bus.digit_valid, 1);
      check("t1_digit", bus.digit_out, 2);
      tick();
      check("t1_drop", bus.digit_valid, 0);
      check("t1_bcd", bcd_value, 8'h02);
      check("t1_count", value_count, 1);
      check("t1_idle", busy, 0);

      // Glitch during SETTLE restarts the count twice.
      strobe(7'b0000110);
      tick();
      bus.seg_in = 7'b1111110;
      tick();
      bus.seg_in = 7'b0000110;
      tick();
      check("t2_not_yet", bus.digit_valid, 0);
      wait_event(lat);
      check("t2_latency", lat, 4);
      check("t2_digit", bus.digit_out, 3);
      tick();
      check("t2_bcd", bcd_value, 8'h23);
      check("t2_count", value_count, 2);

      // Illegal glyph pulses invalid_err once.
      strobe(7'b1111110);
      wait_event(lat);
      check("t3_latency", lat, 4);
      check("t3_err", invalid_err, 1);
      check("t3_novalid", bus.digit_valid, 0);
      tick();
      check("t3_err_pulse", invalid_err, 0);
      check("t3_idle", busy, 0);
      check("t3_bcd", bcd_value, 8'h23);

      // Blank is dropped silently.
      strobe(7'b1111111);
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         saw = saw | bus.digit_valid | invalid_err;
         tick();
      end
      check("t3_blank_silent", saw, 0);
      check("t3_blank_idle", busy, 0);

      // Back-pressure: digit 9 held, strobe while pending ignored.
      bus.digit_ready = 1'b0;
      strobe(7'b0000100);
      wait_event(lat);
      check("t4_latency", lat, 4);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.seg_in     = 7'b1001111;
            bus.seg_strobe = 1'b1;
         end else begin
            bus.seg_strobe = 1'b0;
         end
         tick();
      end
      check("t4_hold_valid", bus.digit_valid, 1);
      check("t4_hold_digit", bus.digit_out, 9);
      bus.digit_ready = 1'b1;
      tick();
      check("t4_bcd", bcd_value, 8'h39);
      check("t4_drop", bus.digit_valid, 0);
      tick();
      check("t4_no_capture", busy, 0);

      // Every canonical glyph decodes.
      for (int i = 0; i < 10; i++) begin
         accept(glyphs[i], 4'(i));
      end
      check("t5_all_bcd", bcd_value, 8'h89);
      check("t5_all_count", value_count, 2);

      // clear, then accept 1, 2, 3.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t6_clear_bcd", bcd_value, 8'h00);
      check("t6_clear_count", value_count, 0);
      accept(glyphs[1], 4'd1);
      check("t6_count1", value_count, 1);
      accept(glyphs[2], 4'd2);
      accept(glyphs[3], 4'd3);
      check("t6_bcd", bcd_value, 8'h23);
      check("t6_count_sat", value_count, 2);

      // clear on the transfer edge wins.
      bus.digit_ready = 1'b0;
      strobe(glyphs[5]);
      wait_event(lat);
      check("t7_latency", lat, 4);
      clear           = 1'b1;
      bus.digit_ready = 1'b1;
      tick();
      clear = 1'b0;
      check("t7_bcd", bcd_value, 8'h00);
      check("t7_count", value_count, 0);
      check("t7_drop", bus.digit_valid, 0);
      check("t7_idle", busy, 0);

      // Reset during EMIT aborts the pending digit.
      accept(glyphs[7], 4'd7);
      check("t8_pre_bcd", bcd_value, 8'h07);
      bus.digit_ready = 1'b0;
      strobe(glyphs[4]);
      wait_event(lat);
      check("t8_valid", bus.digit_valid, 1);
      reset           = 1'b1;
      bus.digit_ready = 1'b1;
      tick();
      reset = 1'b0;
      check("t8_valid_drop", bus.digit_valid, 0);
      check("t8_busy", busy, 0);
      check("t8_bcd", bcd_value, 8'h00);
      check("t8_count", value_count, 0);

      // Alternate 9 glyph without the bottom segment.
      bus.digit_ready = 1'b1;
      strobe(7'b0001100);
      wait_event(lat);
      check("t9_latency", lat, 4);
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
      check("t9_alt_valid", bus.digit_valid, 1);
      check("t9_alt_digit", bus.digit_out, 9);
      tick();
      check("t9_alt_bcd", bcd_value, 8'h09);
`else
      check("t9_alt_err", invalid_err, 1);
      check("t9_alt_novalid", bus.digit_valid, 0);
      tick();
      check("t9_alt_bcd", bcd_value, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

- Sequential capture block that reads a 7-segment glyph bus (segment order a..g, active-low, 0 = lit) and turns it back into a BCD digit.
- It accumulates accepted digits into a multi-digit packed BCD register.
- It is the read-back counterpart of the BCD-to-segment display path: it checks and recovers the value being shown by the sync_counter display chain, or by any source that drives the same glyph encoding.
- It debounces the glyph bus, rejects glyphs that are not digits, and hands each digit off over a valid/ready handshake.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive cycles a glyph must hold before it is decoded; legal range 1..15
- DIGITS, 2, number of BCD digits held in bcd_value; legal range 1..8

Ports (clock and reset are listed first):
- clk  in  1  single system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- seg_in  in  7  glyph bus {a,b,c,d,e,f,g}, active-low
- seg_strobe  in  1  request to capture the glyph currently on seg_in
- clear  in  1  synchronous clear of bcd_value and value_count; reset has priority over it
- digit_out  out  4  decoded BCD digit, held stable while digit_valid is high
- digit_valid  out  1  digit_out is valid
- digit_ready  in  1  the consumer accepts the digit
- invalid_err  out  1  one-cycle pulse when a settled glyph is neither a digit nor blank
- bcd_value  out  4*DIGITS  accepted digits, most recent digit in bits [3:0]
- value_count  out  4  number of digits accepted; saturates at DIGITS
- busy  out  1  high whenever the state is not IDLE

## Operation
Legal glyphs:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Blank is 1111111.

States: IDLE, SETTLE, DECODE, EMIT.
- IDLE:
  - If seg_strobe=1: latch seg_in into the shadow register and set cnt=1.
  - Then go to DECODE if STABLE_CYCLES=1, else go to SETTLE.
  - seg_strobe in any other state is ignored.
- SETTLE:
  - If seg_in matches the shadow register, cnt increments. When cnt reaches STABLE_CYCLES, go to DECODE.
  - If seg_in differs, re-latch the shadow register, set cnt=1 and stay in SETTLE. There is no timeout.
- DECODE (lasts one cycle):
  - Legal digit: register digit_out, set digit_valid=1, go to EMIT.
  - Blank: go to IDLE silently.
  - Any other pattern: pulse invalid_err for exactly one cycle, go to IDLE. digit_out is unchanged.
- EMIT:
  - digit_valid and digit_out hold until digit_ready=1.
  - On the transfer edge:
    - bcd_value = {bcd_value[4*DIGITS-5:0], digit_out}; the oldest digit is discarded once the register is full.
    - value_count = min(value_count+1, DIGITS).
    - digit_valid drops and the state returns to IDLE.
  - digit_ready outside EMIT is ignored.
- clear:
  - Zeroes bcd_value and value_count in any state.
  - A transfer on the same edge as clear is lost: the clear wins.
  - The FSM is not affected.

## Timing
- Reset values: state=IDLE, digit_out=0, digit_valid=0, invalid_err=0, bcd_value=0, value_count=0, busy=0.
- Reset asserted mid-operation aborts any capture or pending digit on the next edge. No transfer occurs.
- Latency with seg_in stable, strobe sampled at edge T:
  - digit_valid or invalid_err is high after edge T+STABLE_CYCLES.
  - STABLE_CYCLES=4 gives 4 cycles; STABLE_CYCLES=1 gives 1 cycle.
- Each glyph change during SETTLE restarts the count. Latency is then measured from the last change.
- If digit_ready is already high when digit_valid rises, the transfer happens on the next edge. Minimum strobe-to-IDLE time is STABLE_CYCLES+1 cycles.
- busy rises after the strobe edge and falls on the edge that enters IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: SEG7_CAPTURE_ALT_GLYPH_EN.
- Defined: DECODE also accepts these alternate glyphs:
  - 6 without the top segment: 1100000
  - 7 with segment f: 0001101
  - 9 without the bottom segment: 0001100
- Not defined: those three patterns are illegal and raise invalid_err. Only the ten canonical glyphs and blank are recognised.

## Test plan
- STABLE_CYCLES=4, seg_in=0010010 held, strobe at edge 0, digit_ready=1 -> digit_valid high after edge 4 with digit_out=2; transfer at edge 5; bcd_value=0x02, value_count=1.
- Strobe with seg_in=0000110; toggle to 1111110 at cycle 2, then back to 0000110 -> SETTLE restarts twice; digit_valid rises 4 cycles after the last change with digit_out=3.
- seg_in=1111110 -> invalid_err is high for exactly one cycle, no digit_valid, bcd_value unchanged. seg_in=1111111 -> no pulse and no digit.
- digit_ready=0 for 10 cycles with digit_out=9 pending, then pulse strobe with seg_in changed -> digit_out stays 9 and the strobe is ignored; on ready, bcd_value shifts in 9.
- DIGITS=2, accept 1, 2, 3 -> bcd_value=0x23, value_count=2. clear -> 0x00 and 0. reset during EMIT -> digit_valid=0 next edge, no shift.
- seg_in=0001100 -> with SEG7_CAPTURE_ALT_GLYPH_EN: digit_out=9. Without it: invalid_err pulse.
